// File: rtl/ofs_fim_eth_if_pkg.sv
// Shared Ethernet interface package: types and constants used by the RX store-and-forward
// packet FIFO (write FSM states, statistics bundle, default error mask).
package ofs_fim_eth_if_pkg;

   localparam int          ETH_PKT_FIFO_MAX_CNT_W    = 64;
   localparam int unsigned ETH_PKT_FIFO_DEF_ERR_MASK = 32'h1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT  = 2'd1,
      DROP = 2'd2
   } t_eth_pkt_fifo_wr_state;

   typedef struct packed {
      logic [ETH_PKT_FIFO_MAX_CNT_W-1:0] pkt_ok;
      logic [ETH_PKT_FIFO_MAX_CNT_W-1:0] drop_err;
      logic [ETH_PKT_FIFO_MAX_CNT_W-1:0] drop_ovf;
   } t_eth_pkt_fifo_stats;

   // Saturating increment limited to the low w bits; clear wins over increment.
   function automatic logic [ETH_PKT_FIFO_MAX_CNT_W-1:0] eth_cnt_sat_inc(
      input logic [ETH_PKT_FIFO_MAX_CNT_W-1:0] v,
      input logic                              inc,
      input logic                              clr,
      input int                                w
   );
      logic [ETH_PKT_FIFO_MAX_CNT_W-1:0] max_v;
      max_v = {ETH_PKT_FIFO_MAX_CNT_W{1'b1}} >> (ETH_PKT_FIFO_MAX_CNT_W - w);
      if (clr)
         return '0;
      else if (inc && (v != max_v))
         return v + 64'd1;
      else
         return v;
   endfunction

endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// Simple dual-port RAM for the packet FIFO: one write port, one read port with a
// registered (1-cycle) read, no reset on storage so it maps onto block RAM.
module eth_pkt_fifo_ram #(
   parameter int WIDTH  = 81,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_addr] <= wr_data;
      if (rd_en)
         rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_axis_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: packets are written speculatively, committed on a clean
// tlast, rewound on error/overflow, and replayed on a backpressured AXIS egress via a 2-deep skid.
module eth_axis_rx_pkt_fifo
   import ofs_fim_eth_if_pkg::*;
#(
   parameter int                 DATA_W      = 64,
   parameter int                 TUSER_W     = 8,
   parameter int                 DEPTH       = 512,
   parameter logic [TUSER_W-1:0] ERR_MASK    = TUSER_W'(ETH_PKT_FIFO_DEF_ERR_MASK),
   parameter bit                 DROP_ON_ERR = 1'b1,
   parameter int                 CNT_W       = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_tvalid,
   input  logic [DATA_W-1:0]        s_tdata,
   input  logic [DATA_W/8-1:0]      s_tkeep,
   input  logic                     s_tlast,
   input  logic [TUSER_W-1:0]       s_tuser,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic [DATA_W/8-1:0]      m_tkeep,
   output logic                     m_tlast,
   output logic [TUSER_W-1:0]       m_tuser,
   input  logic                     clr_cnt,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [CNT_W-1:0]         pkt_ok_cnt,
   output logic [CNT_W-1:0]         drop_err_cnt,
   output logic [CNT_W-1:0]         drop_ovf_cnt
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int RAM_W  = DATA_W + KEEP_W + 1 + TUSER_W;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   t_eth_pkt_fifo_wr_state state_q, state_d;
   logic                   err_q, err_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       ret_ptr_q, ret_ptr_d;
   logic                   rd_vld_q, rd_vld_d;
   logic [1:0]             skid_cnt_q, skid_cnt_d;
   logic [RAM_W-1:0]       skid0_q, skid0_d;
   logic [RAM_W-1:0]       skid1_q, skid1_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic [PTR_W-1:0]       fill_q, fill_d;
   t_eth_pkt_fifo_stats    stats_q, stats_d;

   logic             full, beat_err, err_all;
   logic             inc_ok, inc_err, inc_ovf;
   logic             ram_we, ram_re, push, pop;
   logic [RAM_W-1:0] ram_wdata, ram_rdata;

   // Occupancy is measured against beats already handed off on egress, so slots whose
   // data is still sitting in the read pipeline or skid are never overwritten.
   assign full      = (wr_ptr_q - ret_ptr_q) == PTR_W'(DEPTH);
   assign beat_err  = |(s_tuser & ERR_MASK);
   assign err_all   = beat_err | ((state_q == PKT) && err_q);
   assign ram_wdata = {s_tuser, s_tlast, s_tkeep, s_tdata};

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      ram_we       = 1'b0;
      inc_ok       = 1'b0;
      inc_err      = 1'b0;
      inc_ovf      = 1'b0;
      if (s_tvalid) begin
         case (state_q)
            IDLE, PKT: begin
               if (full) begin
                  wr_ptr_d = commit_ptr_q;
                  err_d    = 1'b0;
                  if (s_tlast) begin
                     inc_ovf = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  if (s_tlast) begin
                     state_d = IDLE;
                     err_d   = 1'b0;
                     if (err_all && DROP_ON_ERR) begin
                        wr_ptr_d = commit_ptr_q;
                        inc_err  = 1'b1;
                     end else begin
                        commit_ptr_d = wr_ptr_q + PTR_W'(1);
                        inc_ok       = 1'b1;
                        inc_err      = err_all;
                     end
                  end else begin
                     state_d = PKT;
                     err_d   = err_all;
                  end
               end
            end
            DROP: begin
               if (s_tlast) begin
                  inc_ovf = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Fetch only if the skid can still absorb this beat next cycle even without a pop.
   always_comb begin
      pop        = m_tvalid_q && m_tready;
      push       = rd_vld_q;
      skid_cnt_d = skid_cnt_q + 2'(push) - 2'(pop);
      ram_re     = (rd_ptr_q != commit_ptr_q) && (skid_cnt_d <= 2'd1);
      rd_ptr_d   = rd_ptr_q + PTR_W'(ram_re);
      rd_vld_d   = ram_re;
      ret_ptr_d  = ret_ptr_q + PTR_W'(pop);
      m_tvalid_d = skid_cnt_d != 2'd0;
      fill_d     = commit_ptr_d - ret_ptr_d;
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      case ({push, pop})
         2'b10: begin
            if (skid_cnt_q == 2'd0)
               skid0_d = ram_rdata;
            else
               skid1_d = ram_rdata;
         end
         2'b01: skid0_d = skid1_q;
         2'b11: begin
            if (skid_cnt_q == 2'd1) begin
               skid0_d = ram_rdata;
            end else begin
               skid0_d = skid1_q;
               skid1_d = ram_rdata;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      stats_d          = stats_q;
      stats_d.pkt_ok   = eth_cnt_sat_inc(stats_q.pkt_ok,   inc_ok,  clr_cnt, CNT_W);
      stats_d.drop_err = eth_cnt_sat_inc(stats_q.drop_err, inc_err, clr_cnt, CNT_W);
      stats_d.drop_ovf = eth_cnt_sat_inc(stats_q.drop_ovf, inc_ovf, clr_cnt, CNT_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         ret_ptr_q    <= '0;
         rd_vld_q     <= 1'b0;
         skid_cnt_q   <= '0;
         skid0_q      <= '0;
         skid1_q      <= '0;
         m_tvalid_q   <= 1'b0;
         fill_q       <= '0;
         stats_q      <= '0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ret_ptr_q    <= ret_ptr_d;
         rd_vld_q     <= rd_vld_d;
         skid_cnt_q   <= skid_cnt_d;
         skid0_q      <= skid0_d;
         skid1_q      <= skid1_d;
         m_tvalid_q   <= m_tvalid_d;
         fill_q       <= fill_d;
         stats_q      <= stats_d;
      end
   end

   eth_pkt_fifo_ram #(
      .WIDTH  (RAM_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (ram_wdata),
      .rd_en   (ram_re),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (ram_rdata)
   );

   assign m_tvalid     = m_tvalid_q;
   assign m_tdata      = skid0_q[DATA_W-1:0];
   assign m_tkeep      = skid0_q[DATA_W +: KEEP_W];
   assign m_tlast      = skid0_q[DATA_W + KEEP_W];
   assign m_tuser      = skid0_q[RAM_W-1 -: TUSER_W];
   assign fill_level   = fill_q;
   assign pkt_ok_cnt   = stats_q.pkt_ok[CNT_W-1:0];
   assign drop_err_cnt = stats_q.drop_err[CNT_W-1:0];
   assign drop_ovf_cnt = stats_q.drop_ovf[CNT_W-1:0];

endmodule

// File: tb/tb_eth_axis_rx_pkt_fifo.sv
// Bench for eth_axis_rx_pkt_fifo: three instances (default, forward-on-error, DEPTH=8) share
// one ingress stream; directed table rows, corner sequences and a scoreboarded random run.
module tb_eth_axis_rx_pkt_fifo;

   typedef logic [80:0] beat_t;

   typedef struct {
      int sel;        // 0 default, 1 forward-on-error, 2 DEPTH=8
      int nrep;
      int len_a;
      int err_a;      // beat index carrying tuser[0], -1 for none
      int len_b;      // optional trailing clean packet, 0 for none
      bit rdy;
      int exp_ok;
      int exp_err;
      int exp_ovf;
      int exp_fill;
      int exp_beats;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic s_tvalid = 1'b0;
   logic [63:0] s_tdata = '0;
   logic [7:0] s_tkeep = '0;
   logic s_tlast = 1'b0;
   logic [7:0] s_tuser = '0;
   logic m_tready = 1'b0;
   logic clr_cnt = 1'b0;

   logic m_tvalid_b, m_tlast_b, m_tvalid_n, m_tlast_n, m_tvalid_s, m_tlast_s;
   logic [63:0] m_tdata_b, m_tdata_n, m_tdata_s;
   logic [7:0] m_tkeep_b, m_tkeep_n, m_tkeep_s, m_tuser_b, m_tuser_n, m_tuser_s;
   logic [9:0] fill_b, fill_n;
   logic [3:0] fill_s;
   logic [31:0] ok_b, err_b, ovf_b, ok_n, err_n, ovf_n, ok_s, err_s, ovf_s;

   int nvec = 0;
   int nerr = 0;
   bit sb_en = 1'b0;
   bit rnd_rdy = 1'b0;
   beat_t q_b[$];
   beat_t q_n[$];
   int beats_b, beats_n, beats_s;
   bit hold_b_v, hold_n_v;
   beat_t hold_b, hold_n;
   beat_t pay_b, pay_n;

   assign pay_b = {m_tuser_b, m_tlast_b, m_tkeep_b, m_tdata_b};
   assign pay_n = {m_tuser_n, m_tlast_n, m_tkeep_n, m_tdata_n};

   always #5 clk = ~clk;

   eth_axis_rx_pkt_fifo u_big (
      .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tvalid(m_tvalid_b), .m_tready(m_tready),
      .m_tdata(m_tdata_b), .m_tkeep(m_tkeep_b), .m_tlast(m_tlast_b), .m_tuser(m_tuser_b),
      .clr_cnt(clr_cnt), .fill_level(fill_b), .pkt_ok_cnt(ok_b), .drop_err_cnt(err_b),
      .drop_ovf_cnt(ovf_b)
   );

   eth_axis_rx_pkt_fifo #(.DROP_ON_ERR(1'b0)) u_noerr (
      .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tvalid(m_tvalid_n), .m_tready(m_tready),
      .m_tdata(m_tdata_n), .m_tkeep(m_tkeep_n), .m_tlast(m_tlast_n), .m_tuser(m_tuser_n),
      .clr_cnt(clr_cnt), .fill_level(fill_n), .pkt_ok_cnt(ok_n), .drop_err_cnt(err_n),
      .drop_ovf_cnt(ovf_n)
   );

   eth_axis_rx_pkt_fifo #(.DEPTH(8)) u_small (
      .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tvalid(m_tvalid_s), .m_tready(m_tready),
      .m_tdata(m_tdata_s), .m_tkeep(m_tkeep_s), .m_tlast(m_tlast_s), .m_tuser(m_tuser_s),
      .clr_cnt(clr_cnt), .fill_level(fill_s), .pkt_ok_cnt(ok_s), .drop_err_cnt(err_s),
      .drop_ovf_cnt(ovf_s)
   );

   function automatic void check(input string nm, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic void check_beat(input string nm, input beat_t act, input beat_t exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic void egress(input string nm, input beat_t act, input bit clean_only);
      if (clean_only ? (q_b.size() == 0) : (q_n.size() == 0)) begin
         nvec++;
         nerr++;
         $display("FAIL %s: got beat %h, expected none", nm, act);
      end else if (clean_only) begin
         check_beat(nm, act, q_b.pop_front());
      end else begin
         check_beat(nm, act, q_n.pop_front());
      end
   endfunction

   // Egress monitor: handshakes seen at the negedge complete on the following posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         beats_b  <= 0;
         beats_n  <= 0;
         beats_s  <= 0;
         hold_b_v <= 1'b0;
         hold_n_v <= 1'b0;
      end else begin
         if (hold_b_v) check_beat("stable_b", {m_tvalid_b, pay_b}, {1'b1, hold_b});
         if (hold_n_v) check_beat("stable_n", {m_tvalid_n, pay_n}, {1'b1, hold_n});
         hold_b_v <= m_tvalid_b && !m_tready;
         hold_n_v <= m_tvalid_n && !m_tready;
         hold_b   <= pay_b;
         hold_n   <= pay_n;
         if (m_tvalid_b && m_tready) begin
            beats_b <= beats_b + 1;
            if (sb_en) egress("egress_b", pay_b, 1'b1);
         end
         if (m_tvalid_n && m_tready) begin
            beats_n <= beats_n + 1;
            if (sb_en) egress("egress_n", pay_n, 1'b0);
         end
         if (m_tvalid_s && m_tready) beats_s <= beats_s + 1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [7:0] u);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tuser  = u;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Reference model: a packet is queued for the default instance only if clean,
   // and always for the forward-on-error instance.
   task automatic send_pkt(input int len, input int errb, input bit gaps);
      beat_t bq[$];
      for (int i = 0; i < len; i++) begin
         logic [63:0] d;
         logic [7:0]  k;
         logic [7:0]  u;
         logic        l;
         if (gaps && ($urandom_range(0, 4) == 0)) begin
            @(posedge clk);
            #1;
         end
         d = {$urandom, $urandom};
         l = (i == len - 1);
         k = l ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
         u = (8'($urandom) & 8'hFE) | ((i == errb) ? 8'h01 : 8'h00);
         bq.push_back({u, l, k, d});
         send_beat(d, k, l, u);
      end
      if (sb_en) begin
         foreach (bq[j]) begin
            q_n.push_back(bq[j]);
            if (errb < 0) q_b.push_back(bq[j]);
         end
      end
   endtask

   task automatic do_reset();
      sb_en = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_b.delete();
      q_n.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 3000; i++) begin
         if (q_b.size() == 0 && q_n.size() == 0) break;
         @(posedge clk);
         #1;
      end
      repeat (4) @(posedge clk);
      #1;
      check(nm, q_b.size() + q_n.size(), 0);
   endtask

   initial begin
      vec_t vecs[7];
      int   cnt;
      int   n_clean;
      int   n_errp;

      vecs[0] = '{0, 4, 3, -1, 0, 1'b1, 4, 0, 0, 0, 12};
      vecs[1] = '{0, 1, 5,  1, 0, 1'b1, 0, 1, 0, 0, 0};
      vecs[2] = '{1, 1, 5,  1, 0, 1'b1, 1, 1, 0, 0, 5};
      vecs[3] = '{2, 1, 6, -1, 4, 1'b0, 1, 0, 1, 6, 0};
      vecs[4] = '{2, 1, 10, -1, 2, 1'b1, 1, 0, 1, 0, 2};
      vecs[5] = '{0, 3, 1, -1, 0, 1'b1, 3, 0, 0, 0, 3};
      vecs[6] = '{0, 1, 1,  0, 2, 1'b1, 1, 1, 0, 0, 2};

      do_reset();
      check("rst_tvalid", m_tvalid_b, 0);
      check("rst_tdata", m_tdata_b, 0);
      check("rst_fill", fill_b, 0);
      check("rst_ok", ok_b, 0);
      check("rst_err", err_b, 0);
      check("rst_ovf", ovf_b, 0);

      // Commit-to-valid latency on an empty egress
      m_tready = 1'b1;
      send_pkt(3, -1, 1'b0);
      cnt = 0;
      while (!m_tvalid_b && cnt < 10) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("latency", cnt, 2);

      for (int r = 0; r < 7; r++) begin
         int a_ok, a_err, a_ovf, a_fill, a_beats;
         do_reset();
         m_tready = vecs[r].rdy;
         repeat (vecs[r].nrep) send_pkt(vecs[r].len_a, vecs[r].err_a, 1'b0);
         if (vecs[r].len_b > 0) send_pkt(vecs[r].len_b, -1, 1'b0);
         repeat (30) @(posedge clk);
         #1;
         case (vecs[r].sel)
            0: begin a_ok = ok_b; a_err = err_b; a_ovf = ovf_b; a_fill = fill_b; a_beats = beats_b; end
            1: begin a_ok = ok_n; a_err = err_n; a_ovf = ovf_n; a_fill = fill_n; a_beats = beats_n; end
            default: begin a_ok = ok_s; a_err = err_s; a_ovf = ovf_s; a_fill = fill_s; a_beats = beats_s; end
         endcase
         check($sformatf("row%0d_ok", r), a_ok, vecs[r].exp_ok);
         check($sformatf("row%0d_err", r), a_err, vecs[r].exp_err);
         check($sformatf("row%0d_ovf", r), a_ovf, vecs[r].exp_ovf);
         check($sformatf("row%0d_fill", r), a_fill, vecs[r].exp_fill);
         check($sformatf("row%0d_beats", r), a_beats, vecs[r].exp_beats);
      end

      // clr_cnt beats a same-cycle commit
      do_reset();
      m_tready = 1'b1;
      send_pkt(2, -1, 1'b0);
      check("clr_pre_ok", ok_b, 1);
      clr_cnt = 1'b1;
      send_beat(64'h1234, 8'hFF, 1'b1, 8'h00);
      clr_cnt = 1'b0;
      check("clr_prio_ok", ok_b, 0);
      send_pkt(1, -1, 1'b0);
      check("clr_post_ok", ok_b, 1);

      // Asynchronous reset mid-packet with packets buffered
      do_reset();
      m_tready = 1'b0;
      repeat (3) send_pkt(3, -1, 1'b0);
      send_beat(64'hAAAA, 8'hFF, 1'b0, 8'h00);
      send_beat(64'hBBBB, 8'hFF, 1'b0, 8'h00);
      check("rstmid_pre_ok", ok_b, 3);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_tvalid", m_tvalid_b, 0);
      check("rstmid_ok", ok_b, 0);
      check("rstmid_fill", fill_b, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_b.delete();
      q_n.delete();
      sb_en = 1'b1;
      m_tready = 1'b1;
      send_pkt(4, -1, 1'b0);
      wait_drain("rstmid_drain");
      check("rstmid_beats", beats_b, 4);
      check("rstmid_post_ok", ok_b, 1);

      // Random packets with random backpressure against the scoreboard
      do_reset();
      sb_en   = 1'b1;
      rnd_rdy = 1'b1;
      n_clean = 0;
      n_errp  = 0;
      for (int p = 0; p < 1000; p++) begin
         int len;
         int eb;
         len = $urandom_range(1, 16);
         if ($urandom_range(0, 99) < 15) begin
            eb = $urandom_range(0, len - 1);
            n_errp++;
         end else begin
            eb = -1;
            n_clean++;
         end
         send_pkt(len, eb, 1'b1);
         repeat ($urandom_range(0, 12)) @(posedge clk);
         #1;
      end
      rnd_rdy = 1'b0;
      #1;
      m_tready = 1'b1;
      wait_drain("rnd_drain");
      check("rnd_ok_b", ok_b, n_clean);
      check("rnd_err_b", err_b, n_errp);
      check("rnd_ovf_b", ovf_b, 0);
      check("rnd_fill_b", fill_b, 0);
      check("rnd_ok_n", ok_n, n_clean + n_errp);
      check("rnd_err_n", err_n, n_errp);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
